// File: rtl/simd_alu_pipe.sv
// Pipelined SIMD integer ALU. It computes on a whole word or on independent lanes, with optional signed saturation.
// Ops retire in issue order behind a valid/ready handshake. A single global enable freezes the pipe on back-pressure.

module simd_alu_elem #(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic         sat,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] WIDTH   = W[W-1:0];

  logic [W-1:0]   sum;
  logic [W-1:0]   neg_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] prod;
  logic           sum_ovf;
  logic           prod_ovf;

  always_comb begin
    sum      = a + b;
    sum_ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    // Sign-extend both operands so the low 2W bits hold the exact signed product.
    prod     = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    prod_ovf = (prod[2*W-1:W-1] != {(W+1){1'b0}}) && (prod[2*W-1:W-1] != {(W+1){1'b1}});
    neg_a    = -a;
    mag_b    = -b;
    result   = '0;
    case (op)
      4'd0: result = (sat && sum_ovf) ? (a[W-1] ? MIN_NEG : MAX_POS) : sum;
      4'd1: result = (sat && prod_ovf) ? (prod[2*W-1] ? MIN_NEG : MAX_POS) : prod[W-1:0];
      4'd2: begin
        // A negative b gives a logical right shift. When b is the most negative value, mag_b wraps to itself,
        // which is still >= W, so the result correctly clears to zero.
        if (!b[W-1]) result = (b >= WIDTH) ? '0 : (a << b);
        else         result = (mag_b >= WIDTH) ? '0 : (a >> mag_b);
      end
      4'd3: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4: result = a & b;
      4'd5: result = a | b;
      4'd6: result = a ^ b;
      4'd7: result = {W{|a}};
      4'd8: result = (sat && (a == MIN_NEG)) ? MAX_POS : neg_a;
      4'd9: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

module simd_alu_pipe #(
  parameter int WORD_W = 16,
  parameter int LANE_W = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_lanes,
  input  logic              in_sat,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int LANES = WORD_W / LANE_W;

  logic [WORD_W-1:0] word_res;
  logic [WORD_W-1:0] lane_res;
  logic [WORD_W-1:0] stage_in;
  logic              illegal;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] err_q;
  logic [WORD_W-1:0] res_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  simd_alu_elem #(.W(WORD_W)) u_word (
    .op     (in_op),
    .sat    (in_sat),
    .a      (in_a),
    .b      (in_b),
    .result (word_res)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    simd_alu_elem #(.W(LANE_W)) u_lane (
      .op     (in_op),
      .sat    (in_sat),
      .a      (in_a[l*LANE_W +: LANE_W]),
      .b      (in_b[l*LANE_W +: LANE_W]),
      .result (lane_res[l*LANE_W +: LANE_W])
    );
  end

  assign illegal  = (in_op > 4'd9);
  assign stage_in = illegal ? '0 : (in_lanes ? lane_res : word_res);
  assign in_ready = !out_valid || out_ready;

  // The whole pipe advances or holds as one unit, so bubbles keep their slots during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (in_ready) begin
      vld_q[0] <= in_valid;
      err_q[0] <= illegal;
      res_q[0] <= stage_in;
      tag_q[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        res_q[i] <= res_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid  = vld_q[STAGES-1];
  assign out_err    = err_q[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe (WORD_W=16, LANE_W=8, STAGES=2).
// Every expected value below is hand-computed from the op definitions.

module tb_simd_alu_pipe;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SH  = 4'd2;
  localparam logic [3:0] OP_SLT = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_ANY = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;

  typedef struct packed {
    logic [3:0]  op;
    logic        lanes;
    logic        sat;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic        in_lanes = 1'b0;
  logic        in_sat = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  simd_alu_pipe #(.WORD_W(16), .LANE_W(8), .STAGES(2), .TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_lanes   (in_lanes),
    .in_sat     (in_sat),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Issue one op with out_ready high. Report the retiring outputs and the cycles from issue to out_valid.
  task automatic run_op(input logic [3:0] op, input logic lanes, input logic sat, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag, output logic [15:0] res,
                        output logic err_o, output logic [3:0] tag_o, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_lanes  = lanes;
    in_sat    = sat;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res   = out_result;
    err_o = out_err;
    tag_o = out_tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_err, out_tag, out_result} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b err=%b tag=%h result=%h, expected all zero",
               out_valid, out_err, out_tag, out_result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    vec_t tbl [5];
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    tbl = '{'{OP_ADD, 1'b1, 1'b0, 16'h7F01, 16'h0102, 16'h8003},
            '{OP_ADD, 1'b1, 1'b1, 16'h7F01, 16'h0102, 16'h7F03},
            '{OP_ADD, 1'b0, 1'b0, 16'h7F01, 16'h0102, 16'h8003},
            '{OP_ADD, 1'b1, 1'b1, 16'h8001, 16'hFF01, 16'h8002},
            '{OP_ADD, 1'b0, 1'b1, 16'h7F01, 16'h0102, 16'h7FFF}};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].lanes, tbl[i].sat, tbl[i].a, tbl[i].b, 4'(i + 1), r, e, t, lat);
      checks++;
      if ({e, t, r} !== {1'b0, 4'(i + 1), tbl[i].exp}) begin
        errors++;
        $display("[TB] FAIL add[%0d]: got err=%b tag=%h result=%h, expected err=0 tag=%h result=%h",
                 i, e, t, r, 4'(i + 1), tbl[i].exp);
      end
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("[TB] FAIL add_latency[%0d]: got %0d cycles expected 2", i, lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t tbl [5];
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    tbl = '{'{OP_MUL, 1'b1, 1'b0, 16'h0310, 16'h0210, 16'h0600},
            '{OP_MUL, 1'b1, 1'b1, 16'h0310, 16'h0210, 16'h067F},
            '{OP_MUL, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'h000F},
            '{OP_MUL, 1'b1, 1'b1, 16'hF003, 16'h1002, 16'h8006},
            '{OP_MUL, 1'b0, 1'b1, 16'h0100, 16'h0100, 16'h7FFF}};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].lanes, tbl[i].sat, tbl[i].a, tbl[i].b, 4'(i + 1), r, e, t, lat);
      checks++;
      if ({e, t, r} !== {1'b0, 4'(i + 1), tbl[i].exp}) begin
        errors++;
        $display("[TB] FAIL mul[%0d]: got err=%b tag=%h result=%h, expected err=0 tag=%h result=%h",
                 i, e, t, r, 4'(i + 1), tbl[i].exp);
      end
    end
  endtask

  task automatic test_shift();
    vec_t tbl [7];
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    tbl = '{'{OP_SH, 1'b0, 1'b0, 16'h0001, 16'h0004, 16'h0010},
            '{OP_SH, 1'b0, 1'b0, 16'h0100, 16'hFFFC, 16'h0010},
            '{OP_SH, 1'b0, 1'b0, 16'hFFFF, 16'h0010, 16'h0000},
            '{OP_SH, 1'b1, 1'b0, 16'h8001, 16'hFF01, 16'h4002},
            '{OP_SH, 1'b1, 1'b0, 16'hC001, 16'h0107, 16'h8080},
            '{OP_SH, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h1234},
            '{OP_SH, 1'b0, 1'b0, 16'h8000, 16'hFFF1, 16'h0001}};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].lanes, tbl[i].sat, tbl[i].a, tbl[i].b, 4'(i + 1), r, e, t, lat);
      checks++;
      if ({e, t, r} !== {1'b0, 4'(i + 1), tbl[i].exp}) begin
        errors++;
        $display("[TB] FAIL sh[%0d]: got err=%b tag=%h result=%h, expected err=0 tag=%h result=%h",
                 i, e, t, r, 4'(i + 1), tbl[i].exp);
      end
    end
  endtask

  task automatic test_misc_ops();
    vec_t tbl [13];
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    tbl = '{'{OP_SLT, 1'b1, 1'b0, 16'h8005, 16'h0106, 16'h0101},
            '{OP_SLT, 1'b0, 1'b0, 16'h0005, 16'hFFFF, 16'h0000},
            '{OP_SLT, 1'b0, 1'b0, 16'hFFFF, 16'h0005, 16'h0001},
            '{OP_AND, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000},
            '{OP_OR,  1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFF0},
            '{OP_XOR, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0},
            '{OP_NOT, 1'b0, 1'b1, 16'h1234, 16'h5555, 16'hEDCB},
            '{OP_ANY, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hFF00},
            '{OP_ANY, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000},
            '{OP_NEG, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h8000},
            '{OP_NEG, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h7FFF},
            '{OP_NEG, 1'b1, 1'b1, 16'h0180, 16'h0000, 16'hFF7F},
            '{OP_NEG, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h00FD}};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].lanes, tbl[i].sat, tbl[i].a, tbl[i].b, 4'(i + 1), r, e, t, lat);
      checks++;
      if ({e, t, r} !== {1'b0, 4'(i + 1), tbl[i].exp}) begin
        errors++;
        $display("[TB] FAIL misc[%0d] op=%0d: got err=%b tag=%h result=%h, expected err=0 tag=%h result=%h",
                 i, tbl[i].op, e, t, r, 4'(i + 1), tbl[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int retired = 0;
    int stall_left = -1;
    int extra = 0;
    logic [15:0] held_res = '0;
    logic [3:0]  held_tag = '0;
    for (int cyc = 0; cyc < 40 && retired < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && stall_left < 0) begin
        stall_left = 3;
        held_res   = out_result;
        held_tag   = out_tag;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left < 3) begin
          checks++;
          if ({out_valid, out_tag, out_result} !== {1'b1, held_tag, held_res}) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got valid=%b tag=%h result=%h, expected valid=1 tag=%h result=%h",
                     out_valid, out_tag, out_result, held_tag, held_res);
          end
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_in_ready_stall: got %b expected 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({out_err, out_tag, out_result} !== {1'b0, 4'(retired + 1), 16'(16'h1000 * (retired + 1) + retired + 1)}) begin
          errors++;
          $display("[TB] FAIL b2b_retire[%0d]: got err=%b tag=%h result=%h, expected err=0 tag=%h result=%h",
                   retired, out_err, out_tag, out_result, 4'(retired + 1), 16'(16'h1000 * (retired + 1) + retired + 1));
        end
        retired++;
      end
      if (issued < 4) begin
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_lanes = 1'b0;
        in_sat   = 1'b0;
        in_a     = 16'(16'h1000 * (issued + 1));
        in_b     = 16'(issued + 1);
        in_tag   = 4'(issued + 1);
        if (in_ready) issued++;
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (retired !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d retirements expected 4", retired);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_no_duplicate: got %0d extra valid cycles expected 0", extra);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    run_op(4'hF, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 4'd9, r, e, t, lat);
    checks++;
    if ({e, t, r} !== {1'b1, 4'h9, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL illegal: got err=%b tag=%h result=%h, expected err=1 tag=9 result=0000", e, t, r);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL illegal_latency: got %0d cycles expected 2", lat);
    end
  endtask

  task automatic test_reset_in_flight();
    logic [15:0] r;
    logic e;
    logic [3:0] t;
    int lat;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = OP_ADD;
    in_lanes  = 1'b0;
    in_sat    = 1'b0;
    in_a      = 16'h0001;
    in_b      = 16'h0001;
    in_tag    = 4'd5;
    @(negedge clk);
    in_a   = 16'h0002;
    in_b   = 16'h0002;
    in_tag = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_err, out_tag, out_result} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_flight_outputs: got valid=%b err=%b tag=%h result=%h, expected all zero",
               out_valid, out_err, out_tag, out_result);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_flight_leak: got %0d valid cycles expected 0", seen);
    end
    run_op(OP_ADD, 1'b1, 1'b0, 16'h0102, 16'h0304, 4'd7, r, e, t, lat);
    checks++;
    if ({e, t, r} !== {1'b0, 4'h7, 16'h0406}) begin
      errors++;
      $display("[TB] FAIL reset_flight_next: got err=%b tag=%h result=%h, expected err=0 tag=7 result=0406", e, t, r);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL reset_flight_latency: got %0d cycles expected 2", lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_shift();
    test_misc_ops();
    test_back_to_back();
    test_illegal();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

endmodule
